// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - instruction fetch/decode sequencer driving the PC counter and dispatch handshake
module fetch_decode_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    input  logic [7:0] pc_in_i,
    output logic       pc_en_o,
    output logic       pc_load_o,
    output logic [7:0] pc_load_value_o,
    output logic [7:0] mem_addr_o,
    output logic       mem_rd_o,
    input  logic [7:0] mem_rdata_i,
    input  logic       zero_flag_i,
    output logic [7:0] ir_o,
    output logic       exec_valid_o,
    input  logic       exec_ready_i,
    output logic [3:0] exec_op_o,
    output logic [7:0] exec_operand_o,
    output logic       halted_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F1,
        ST_F2,
        ST_DEC,
        ST_O1,
        ST_O2,
        ST_EXEC,
        ST_JUMP,
        ST_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] operand_q, operand_d;

    logic       pc_en_c;
    logic       pc_load_c;
    logic [7:0] pc_load_value_c;
    logic       mem_rd_c;
    logic       exec_valid_c;
    logic       halted_c;
    logic [3:0] opcode;

    assign opcode = ir_q[7:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        operand_d       = operand_q;
        pc_en_c         = 1'b0;
        pc_load_c       = 1'b0;
        pc_load_value_c = 8'h00;
        mem_rd_c        = 1'b0;
        exec_valid_c    = 1'b0;
        halted_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_F1;
                end
            end
            ST_F1: begin
                mem_rd_c = 1'b1;
                state_d  = ST_F2;
            end
            ST_F2: begin
                ir_d    = mem_rdata_i;
                pc_en_c = 1'b1;
                state_d = ST_DEC;
            end
            ST_DEC: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = ST_EXEC;
                    4'h8, 4'h9, 4'hA:                         state_d = ST_O1;
                    4'hF:                                     state_d = ST_HALT;
                    default:                                  state_d = ST_F1;
                endcase
            end
            ST_O1: begin
                mem_rd_c = 1'b1;
                state_d  = ST_O2;
            end
            ST_O2: begin
                operand_d = mem_rdata_i;
                pc_en_c   = 1'b1;
                case (opcode)
                    4'h8:    state_d = ST_EXEC;
                    4'h9:    state_d = ST_JUMP;
                    4'hA:    state_d = zero_flag_i ? ST_JUMP : ST_F1;
                    default: state_d = ST_F1;
                endcase
            end
            ST_EXEC: begin
                exec_valid_c = 1'b1;
                if (exec_ready_i) begin
                    state_d = ST_F1;
                end
            end
            ST_JUMP: begin
                pc_en_c         = 1'b1;
                pc_load_c       = 1'b1;
                pc_load_value_c = operand_q;
                state_d         = ST_F1;
            end
            ST_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset forces the counter enable so the external PC clears alongside us.
    assign pc_en_o         = reset | pc_en_c;
    assign pc_load_o       = pc_load_c;
    assign pc_load_value_o = pc_load_value_c;
    assign mem_addr_o      = pc_in_i;
    assign mem_rd_o        = mem_rd_c;
    assign ir_o            = ir_q;
    assign exec_valid_o    = exec_valid_c;
    assign exec_op_o       = opcode;
    assign exec_operand_o  = (opcode == 4'h8) ? operand_q : {4'h0, ir_q[3:0]};
    assign halted_o        = halted_c;

endmodule
